// File: rtl/mc_controller.sv
// mc_controller: multi-cycle RV32I-subset control FSM.
// Three-process FSM (state reg / next-state / outputs), combinational
// ALU and immediate decoders, plus a retired-instruction counter and a
// sticky illegal-opcode flag for debug.
module mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  output logic             pc_write,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             we,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_srca,
  output logic [1:0]       alu_srcb,
  output logic [1:0]       imm_src,
  output logic [2:0]       alu_cntrl,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0] state_q, state_d;
  logic       legal_op;
  logic       retire;
  logic [2:0] alu_fn;
  logic       pc_write_raw, mem_write_raw, ir_write_raw, we_raw;

  assign state = state_q;

  // Opcode legality, used by DECODE to flag unsupported instructions.
  always_comb begin
    legal_op = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: legal_op = 1'b1;
      default:                                  legal_op = 1'b0;
    endcase
  end

  // Immediate format follows op alone, in every state.
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // ALU function for EXECR/EXECI; only an R-type with instr[30] subtracts.
  always_comb begin
    alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  alu_fn = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_fn = ALU_SLT;
      3'b110:  alu_fn = ALU_OR;
      3'b111:  alu_fn = ALU_AND;
      default: alu_fn = ALU_ADD;
    endcase
  end

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state datapath controls; unused encodings drive everything to 0.
  always_comb begin
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    we_raw        = 1'b0;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_srca      = 2'b00;
    alu_srcb      = 2'b00;
    alu_cntrl     = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        alu_srcb     = 2'b10;
        result_src   = 2'b10;
        pc_write_raw = 1'b1;
      end
      S_DECODE: begin
        alu_srca = 2'b01;
        alu_srcb = 2'b01;
      end
      S_MEMADR: begin
        alu_srca = 2'b10;
        alu_srcb = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        we_raw     = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        alu_srca  = 2'b10;
        alu_cntrl = alu_fn;
      end
      S_EXECI: begin
        alu_srca  = 2'b10;
        alu_srcb  = 2'b01;
        alu_cntrl = alu_fn;
      end
      S_ALUWB: we_raw = 1'b1;
      S_JAL: begin
        alu_srca     = 2'b01;
        alu_srcb     = 2'b10;
        pc_write_raw = 1'b1;
      end
      S_BEQ: begin
        alu_srca     = 2'b10;
        alu_cntrl    = ALU_SUB;
        pc_write_raw = zero;
      end
      default: ;
    endcase
  end

  // Write enables are held off for as long as reset is low.
  assign pc_write  = pc_write_raw  & reset;
  assign mem_write = mem_write_raw & reset;
  assign ir_write  = ir_write_raw  & reset;
  assign we        = we_raw        & reset;

  assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                  (state_q == S_ALUWB) || (state_q == S_BEQ);

  // Sticky flag: set when DECODE sees an unsupported opcode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               illegal <= 1'b0;
    else if (state_q == S_DECODE && !legal_op) illegal <= 1'b1;
  end

  // Count instructions on their final cycle; wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench. Each instruction pushes its expected
// per-cycle control word (plus retired/illegal) into a queue; every cycle
// pops one entry and compares against the DUT. A narrow counter exercises wrap.
module tb_mc_controller;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             zero;
  logic             pc_write, mem_write, adr_src, ir_write, we;
  logic [1:0]       result_src, alu_srca, alu_srcb, imm_src;
  logic [2:0]       alu_cntrl;
  logic [3:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  mc_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pc_write(pc_write), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .we(we), .result_src(result_src), .alu_srca(alu_srca),
    .alu_srcb(alu_srcb), .imm_src(imm_src), .alu_cntrl(alu_cntrl),
    .state(state), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0]      w;
    logic [CNT_W-1:0] ret;
    logic             ill;
  } exp_t;

  exp_t             sb[$];
  int               n_chk  = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] m_ret  = '0;
  logic             m_ill  = 1'b0;

  // Enable bits: pc_write, mem_write, ir_write, we.
  localparam logic [19:0] EN_MASK = 20'hD8000;

  wire [19:0] obs = {pc_write, mem_write, adr_src, ir_write, we, result_src,
                     alu_srca, alu_srcb, imm_src, alu_cntrl, state};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Control word {pcw,mw,adr,irw,we,rs,sa,sb,imm,alu,state} from the state table.
  function automatic logic [19:0] cw(input logic [3:0] st, input logic [2:0] alu,
                                     input logic z, input logic [1:0] imm);
    case (st)
      4'd0:    return {5'b10010, 2'b10, 2'b00, 2'b10, imm, 3'b000, st};
      4'd1:    return {5'b00000, 2'b00, 2'b01, 2'b01, imm, 3'b000, st};
      4'd2:    return {5'b00000, 2'b00, 2'b10, 2'b01, imm, 3'b000, st};
      4'd3:    return {5'b00100, 2'b00, 2'b00, 2'b00, imm, 3'b000, st};
      4'd4:    return {5'b00001, 2'b01, 2'b00, 2'b00, imm, 3'b000, st};
      4'd5:    return {5'b01100, 2'b00, 2'b00, 2'b00, imm, 3'b000, st};
      4'd6:    return {5'b00000, 2'b00, 2'b10, 2'b00, imm, alu,    st};
      4'd7:    return {5'b00000, 2'b00, 2'b10, 2'b01, imm, alu,    st};
      4'd8:    return {5'b00001, 2'b00, 2'b00, 2'b00, imm, 3'b000, st};
      4'd9:    return {5'b10000, 2'b00, 2'b01, 2'b10, imm, 3'b000, st};
      4'd10:   return {z, 4'b0000, 2'b00, 2'b10, 2'b00, imm, 3'b001, st};
      default: return 20'h0;
    endcase
  endfunction

  // Drive one instruction starting at a negedge; abort_n>0 stops inside
  // that cycle (no retirement, caller handles what follows).
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input logic [2:0] alu, input logic [1:0] imm,
                           input int abort_n);
    logic [3:0] seq[$];
    exp_t e;
    int   n;
    logic legal;
    legal = 1'b1;
    case (o)
      7'b0000011: seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      7'b0100011: seq = '{4'd0, 4'd1, 4'd2, 4'd5};
      7'b0110011: seq = '{4'd0, 4'd1, 4'd6, 4'd8};
      7'b0010011: seq = '{4'd0, 4'd1, 4'd7, 4'd8};
      7'b1101111: seq = '{4'd0, 4'd1, 4'd9, 4'd8};
      7'b1100011: seq = '{4'd0, 4'd1, 4'd10};
      default: begin seq = '{4'd0, 4'd1}; legal = 1'b0; end
    endcase
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    foreach (seq[i]) begin
      e.w   = cw(seq[i], alu, z, imm);
      e.ret = m_ret;
      e.ill = m_ill;
      sb.push_back(e);
    end
    n = (abort_n > 0) ? abort_n : seq.size();
    for (int i = 0; i < n; i++) begin
      #1;
      e = sb.pop_front();
      check($sformatf("ctl op=%b c%0d", o, i), 32'(obs), 32'(e.w));
      check("retired", 32'(retired), 32'(e.ret));
      check("illegal", 32'(illegal), 32'(e.ill));
      if (abort_n > 0 && i == n - 1) break;
      @(negedge clk);
    end
    sb.delete();
    if (abort_n == 0) begin
      if (legal) m_ret = m_ret + CNT_W'(1);
      else       m_ill = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
    // Reset held low: FETCH values with enables forced off.
    repeat (3) begin
      @(negedge clk); #1;
      check("rst ctl", 32'(obs), 32'(cw(4'd0, 3'b000, 1'b0, 2'b00) & ~EN_MASK));
      check("rst retired", 32'(retired), 32'd0);
      check("rst illegal", 32'(illegal), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, 2'b00, 0); // lw
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 3'b000, 2'b01, 0); // sw
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 3'b001, 2'b00, 0); // sub
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 3'b000, 2'b00, 0); // addi, instr[30]=1
    run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 3'b010, 2'b00, 0); // and
    run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 3'b011, 2'b00, 0); // or
    run_instr(7'b0010011, 3'b010, 1'b0, 1'b1, 3'b101, 2'b00, 0); // slti
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 3'b000, 2'b11, 0); // jal
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 3'b000, 2'b10, 0); // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 3'b000, 2'b10, 0); // beq not taken
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 0); // illegal
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, 2'b00, 0); // lw, illegal sticks
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 3'b000, 2'b01, 0); // sw
    run_instr(7'b0110011, 3'b001, 1'b1, 1'b0, 3'b000, 2'b00, 0); // funct3 001 -> add
    // Abort sw inside MEMWRITE with an asynchronous reset.
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 3'b000, 2'b01, 4);
    #1 reset = 1'b0;
    #1;
    check("abort mem_write", 32'(mem_write), 32'd0);
    check("abort ctl", 32'(obs), 32'(cw(4'd0, 3'b000, 1'b0, 2'b01) & ~EN_MASK));
    check("abort retired", 32'(retired), 32'd0);
    check("abort illegal", 32'(illegal), 32'd0);
    m_ret = '0; m_ill = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, 2'b00, 0); // lw after reset
    #1;
    check("final retired", 32'(retired), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
